// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared uart_device register map, flag bit positions and the
//               uart_stream_ctrl state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [7:0] UART_REG_ID    = 8'h00;
    localparam logic [7:0] UART_REG_FLAGS = 8'h01;
    localparam logic [7:0] UART_REG_BAUD  = 8'h02;
    localparam logic [7:0] UART_REG_TX    = 8'h03;
    localparam logic [7:0] UART_REG_RX    = 8'h04;

    localparam int FLAG_WRITE_READY = 8;
    localparam int FLAG_RX_READY    = 9;
    localparam int FLAG_IN_PROGRESS = 10;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_FETCH  = 3'd1;
    localparam logic [STATE_W-1:0] ST_FWAIT  = 3'd2;
    localparam logic [STATE_W-1:0] ST_POLL   = 3'd3;
    localparam logic [STATE_W-1:0] ST_WRITE  = 3'd4;
    localparam logic [STATE_W-1:0] ST_DRAIN  = 3'd5;
    localparam logic [STATE_W-1:0] ST_FINISH = 3'd6;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_FWAIT  = ST_FWAIT,
        S_POLL   = ST_POLL,
        S_WRITE  = ST_WRITE,
        S_DRAIN  = ST_DRAIN,
        S_FINISH = ST_FINISH
    } state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_stream_ctrl
// Description : Streams a byte buffer from word memory into the uart_device TX
//               register, polling write_ready before each byte. Optional
//               UART_STREAM_DRAIN_EN waits for the line to go idle before done.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_stream_ctrl
    import uart_pkg::*;
#(
    parameter logic [15:0] POLL_LIMIT = 16'hFFFF,
    parameter int          ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [15:0]           byte_count,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [15:0]           mem_data,
    output logic                  dev_control,
    output logic                  dev_write_en,
    output logic [7:0]            dev_address,
    output logic [15:0]           dev_data_out,
    input  logic [15:0]           dev_data_in
);

    state_e                r_state;
    state_e                w_next;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [15:0]           r_count;
    logic [15:0]           r_byte_idx;
    logic [15:0]           r_word;
    logic [15:0]           r_poll_cnt;
    logic                  r_error;

    logic       w_latch;
    logic       w_idx_inc;
    logic       w_poll_clr;
    logic       w_poll_inc;
    logic       w_timeout;
    logic       w_poll_expired;
    logic [7:0] w_byte;
    logic       w_unused;

    assign w_poll_expired = (POLL_LIMIT != 16'd0) && (r_poll_cnt == POLL_LIMIT - 16'd1);
    assign w_byte         = r_byte_idx[0] ? r_word[15:8] : r_word[7:0];

`ifdef UART_STREAM_DRAIN_EN
    assign w_unused = &{1'b0, dev_data_in[15:11], dev_data_in[9], dev_data_in[7:0]};
`else
    assign w_unused = &{1'b0, dev_data_in[15:9], dev_data_in[7:0]};
`endif

    always_comb begin
        w_next     = r_state;
        w_latch    = 1'b0;
        w_idx_inc  = 1'b0;
        w_poll_clr = 1'b0;
        w_poll_inc = 1'b0;
        w_timeout  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_latch = 1'b1;
                    w_next  = (byte_count == 16'd0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: w_next = S_FWAIT;
            S_FWAIT: w_next = S_POLL;
            S_POLL: begin
                if (dev_data_in[FLAG_WRITE_READY]) begin
                    w_next     = S_WRITE;
                    w_poll_clr = 1'b1;
                end else if (w_poll_expired) begin
                    w_next    = S_IDLE;
                    w_timeout = 1'b1;
                end else begin
                    w_poll_inc = 1'b1;
                end
            end
            S_WRITE: begin
                w_idx_inc = 1'b1;
                if (r_byte_idx + 16'd1 == r_count) begin
`ifdef UART_STREAM_DRAIN_EN
                    w_next = S_DRAIN;
`else
                    w_next = S_FINISH;
`endif
                // odd index just sent means the next byte starts a new word
                end else if (r_byte_idx[0]) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_POLL;
                end
            end
`ifdef UART_STREAM_DRAIN_EN
            S_DRAIN: begin
                if (!dev_data_in[FLAG_IN_PROGRESS] && dev_data_in[FLAG_WRITE_READY]) begin
                    w_next     = S_FINISH;
                    w_poll_clr = 1'b1;
                end else if (w_poll_expired) begin
                    w_next    = S_IDLE;
                    w_timeout = 1'b1;
                end else begin
                    w_poll_inc = 1'b1;
                end
            end
`endif
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        // abort overrides everything, including a start seen in IDLE
        if (abort) begin
            w_next    = S_IDLE;
            w_latch   = 1'b0;
            w_timeout = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_count    <= 16'd0;
            r_byte_idx <= 16'd0;
            r_word     <= 16'd0;
            r_poll_cnt <= 16'd0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_error <= w_timeout;
            if (w_latch) begin
                r_base     <= base_addr;
                r_count    <= byte_count;
                r_byte_idx <= 16'd0;
                r_poll_cnt <= 16'd0;
            end else begin
                if (w_idx_inc) begin
                    r_byte_idx <= r_byte_idx + 16'd1;
                end
                if (w_poll_clr) begin
                    r_poll_cnt <= 16'd0;
                end else if (w_poll_inc) begin
                    r_poll_cnt <= r_poll_cnt + 16'd1;
                end
            end
            if (r_state == S_FWAIT) begin
                r_word <= mem_data;
            end
        end
    end

    always_comb begin
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_FINISH);
        error        = r_error;
        mem_read     = 1'b0;
        mem_address  = '0;
        dev_control  = 1'b0;
        dev_write_en = 1'b0;
        dev_address  = 8'h00;
        dev_data_out = 16'h0000;
        unique case (r_state)
            S_FETCH: begin
                mem_read    = 1'b1;
                mem_address = r_base + ADDR_WIDTH'(r_byte_idx[15:1]);
            end
            S_POLL: begin
                dev_control = 1'b1;
                dev_address = UART_REG_FLAGS;
            end
`ifdef UART_STREAM_DRAIN_EN
            S_DRAIN: begin
                dev_control = 1'b1;
                dev_address = UART_REG_FLAGS;
            end
`endif
            S_WRITE: begin
                dev_control  = 1'b1;
                dev_write_en = 1'b1;
                dev_address  = UART_REG_TX;
                dev_data_out = {8'h00, w_byte};
            end
            default: ;
        endcase
    end

endmodule : uart_stream_ctrl
`default_nettype wire
